// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver (DATA_BITS 5..9, optional odd/even
// parity, 1 or 2 stop bits) with a valid/ready output handshake, parity and
// framing error flags, false-start rejection and overrun reporting.
// Optional build macro UART_RX_MAJORITY_EN: each bit is the 2-of-3 majority of
// samples taken at clk_cnt HALF-1, HALF and HALF+1, decided at HALF+1, which
// rejects single-cycle glitches. Without the macro a single sample at HALF is used.
module uart_rx_param #(
    parameter int CLK_FREQ  = 65000000,
    parameter int UART_BPS  = 115200,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    input  logic                 uart_rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int BPS_CNT = CLK_FREQ / UART_BPS;
    localparam int HALF    = BPS_CNT / 2;
    localparam int CNT_W   = $clog2(BPS_CNT);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BPS_CNT - 1);
    localparam logic [3:0]       BIT_LAST  = 4'(DATA_BITS - 1);
    localparam logic [1:0]       STOP_LAST = 2'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BREAK
    } state_t;

    state_t               state;
    state_t               state_next;
    logic                 rxd_meta;
    logic                 rxd_sync;
    logic                 rxd_prev;
    logic                 start_edge;
    logic [CNT_W-1:0]     clk_cnt;
    logic                 bit_end;
    logic                 sample_tick;
    logic                 sample_bit;
    logic [3:0]           bit_cnt;
    logic [1:0]           stop_cnt;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 par_err_reg;
    logic                 par_expected;
    logic                 frame_done;

    // Two-flop synchroniser plus one history flop for falling-edge detection; idle-high reset avoids a false edge
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rxd_meta <= 1'b1;
            rxd_sync <= 1'b1;
            rxd_prev <= 1'b1;
        end else begin
            rxd_meta <= uart_rxd;
            rxd_sync <= rxd_meta;
            rxd_prev <= rxd_sync;
        end
    end

    assign start_edge = rxd_prev & ~rxd_sync;
    assign bit_end    = (clk_cnt == CNT_LAST);
    assign busy       = (state != ST_IDLE);

`ifdef UART_RX_MAJORITY_EN
    localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(HALF);
    localparam logic [CNT_W-1:0] CNT_POST = CNT_W'(HALF + 1);

    logic maj_s0;
    logic maj_s1;

    // Capture the two early samples of the majority window; the third is the live line at HALF+1
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            maj_s0 <= 1'b1;
            maj_s1 <= 1'b1;
        end else begin
            if (clk_cnt == CNT_PRE) maj_s0 <= rxd_sync;
            if (clk_cnt == CNT_MID) maj_s1 <= rxd_sync;
        end
    end

    assign sample_tick = (clk_cnt == CNT_POST);
    assign sample_bit  = (maj_s0 & maj_s1) | (maj_s0 & rxd_sync) | (maj_s1 & rxd_sync);
`else
    localparam logic [CNT_W-1:0] CNT_MID = CNT_W'(HALF);

    assign sample_tick = (clk_cnt == CNT_MID);
    assign sample_bit  = rxd_sync;
`endif

    // Parity bit value a correct transmitter would send for the word just shifted in
    always_comb begin
        par_expected = ^shift_reg;
        if (PARITY == 1) par_expected = ~(^shift_reg);
    end

    // State register
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) state <= ST_IDLE;
        else            state <= state_next;
    end

    // Next-state logic; bits advance at the end of each bit period, except false start and last stop bit which act at the sample point
    always_comb begin
        state_next = state;
        frame_done = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_edge) state_next = ST_START;
            end
            ST_START: begin
                if (sample_tick && sample_bit) state_next = ST_IDLE;
                else if (bit_end)              state_next = ST_DATA;
            end
            ST_DATA: begin
                if (bit_end && bit_cnt == BIT_LAST)
                    state_next = (PARITY != 0) ? ST_PARITY : ST_STOP;
            end
            ST_PARITY: begin
                if (bit_end) state_next = ST_STOP;
            end
            ST_STOP: begin
                if (sample_tick) begin
                    if (!sample_bit) begin
                        frame_done = 1'b1;
                        state_next = ST_BREAK;
                    end else if (stop_cnt == STOP_LAST) begin
                        frame_done = 1'b1;
                        state_next = ST_IDLE;
                    end
                end
            end
            ST_BREAK: begin
                if (rxd_sync) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Bit-period counter: restarts on every state entry and wraps each bit; parked at 0 in IDLE and BREAK
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)
            clk_cnt <= '0;
        else if (state_next != state || state == ST_IDLE || state == ST_BREAK || bit_end)
            clk_cnt <= '0;
        else
            clk_cnt <= clk_cnt + 1'b1;
    end

    // Data/stop bit indices and LSB-first data shifter
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            bit_cnt   <= '0;
            stop_cnt  <= '0;
            shift_reg <= '0;
        end else begin
            if (state != ST_DATA) bit_cnt <= '0;
            else if (bit_end)     bit_cnt <= bit_cnt + 1'b1;
            if (state != ST_STOP) stop_cnt <= '0;
            else if (bit_end)     stop_cnt <= stop_cnt + 1'b1;
            if (state == ST_DATA && sample_tick)
                shift_reg <= {sample_bit, shift_reg[DATA_BITS-1:1]};
        end
    end

    // Parity check result for the frame in flight, cleared while idle
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)
            par_err_reg <= 1'b0;
        else if (state == ST_IDLE)
            par_err_reg <= 1'b0;
        else if (state == ST_PARITY && sample_tick)
            par_err_reg <= (sample_bit != par_expected);
    end

    // Output handshake: deliver a completed word if the slot is free or being drained, otherwise drop it and flag overrun
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (frame_done) begin
                if (!rx_valid || rx_ready) begin
                    rx_data    <= shift_reg;
                    parity_err <= par_err_reg;
                    frame_err  <= ~sample_bit;
                    rx_valid   <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: directed bench for uart_rx_param. Two instances: an 8N1
// receiver and a 7-bit even-parity receiver, both at 64 clocks per bit.
module tb_uart_rx_param;

    localparam int CLK_FREQ = 6400000;
    localparam int UART_BPS = 100000;
    localparam int BPS      = CLK_FREQ / UART_BPS;
`ifdef UART_RX_MAJORITY_EN
    localparam int LAT_EXP  = 10 * BPS - BPS / 2 + 5;
`else
    localparam int LAT_EXP  = 10 * BPS - BPS / 2 + 4;
`endif

    logic       sys_clk = 1'b0;
    logic       sys_rst_n;
    logic       rxd;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       parity_err;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    logic       rxd_p;
    logic [6:0] rx_data_p;
    logic       rx_valid_p;
    logic       rx_ready_p;
    logic       parity_err_p;
    logic       frame_err_p;
    logic       overrun_p;
    logic       busy_p;

    int errors = 0;
    int checks = 0;

    int         valid_cnt = 0;
    int         ovr_cnt   = 0;
    logic [7:0] last_data;
    logic       last_pe;
    logic       last_fe;
    int         p_valid_cnt = 0;
    logic [6:0] p_last_data;
    logic       p_last_pe;
    logic       p_last_fe;

    always #5 sys_clk = ~sys_clk;

    uart_rx_param #(
        .CLK_FREQ(CLK_FREQ), .UART_BPS(UART_BPS),
        .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)
    ) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .uart_rxd(rxd),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .parity_err(parity_err), .frame_err(frame_err),
        .overrun(overrun), .busy(busy)
    );

    uart_rx_param #(
        .CLK_FREQ(CLK_FREQ), .UART_BPS(UART_BPS),
        .DATA_BITS(7), .PARITY(2), .STOP_BITS(1)
    ) dut_p (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .uart_rxd(rxd_p),
        .rx_data(rx_data_p), .rx_valid(rx_valid_p), .rx_ready(rx_ready_p),
        .parity_err(parity_err_p), .frame_err(frame_err_p),
        .overrun(overrun_p), .busy(busy_p)
    );

    // Record every delivered word and overrun pulse of the 8N1 receiver
    always @(negedge sys_clk) begin
        if (rx_valid === 1'b1) begin
            valid_cnt = valid_cnt + 1;
            last_data = rx_data;
            last_pe   = parity_err;
            last_fe   = frame_err;
        end
        if (overrun === 1'b1) ovr_cnt = ovr_cnt + 1;
    end

    // Record every delivered word of the parity receiver
    always @(negedge sys_clk) begin
        if (rx_valid_p === 1'b1) begin
            p_valid_cnt = p_valid_cnt + 1;
            p_last_data = rx_data_p;
            p_last_pe   = parity_err_p;
            p_last_fe   = frame_err_p;
        end
    end

    function automatic logic [15:0] frame8(input logic [7:0] d);
        return {6'b0, 1'b1, d, 1'b0};
    endfunction

    task automatic send_bits(input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            rxd = bits[i];
            repeat (BPS) @(negedge sys_clk);
        end
    endtask

    task automatic send_bits_p(input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            rxd_p = bits[i];
            repeat (BPS) @(negedge sys_clk);
        end
    endtask

    task automatic test_reset;
        sys_rst_n  = 1'b0;
        rxd        = 1'b1;
        rxd_p      = 1'b1;
        rx_ready   = 1'b1;
        rx_ready_p = 1'b1;
        repeat (3) @(negedge sys_clk);
        checks++;
        if ({rx_valid, parity_err, frame_err, overrun, busy} !== 5'b0) begin
            errors++;
            $display("[TB] FAIL reset_flags: got %b expected 00000", {rx_valid, parity_err, frame_err, overrun, busy});
        end
        checks++;
        if (rx_data !== 8'h00) begin
            errors++;
            $display("[TB] FAIL reset_data: got %h expected 00", rx_data);
        end
        checks++;
        if ({rx_valid_p, busy_p, rx_data_p} !== 9'b0) begin
            errors++;
            $display("[TB] FAIL reset_parity_dut: got %b expected 0", {rx_valid_p, busy_p, rx_data_p});
        end
        sys_rst_n = 1'b1;
        repeat (5) @(negedge sys_clk);
    endtask

    task automatic test_8n1;
        int v0;
        int o0;
        int lat;
        v0  = valid_cnt;
        o0  = ovr_cnt;
        lat = 0;
        @(negedge sys_clk);
        fork
            send_bits(frame8(8'hA5), 10);
            begin
                while (rx_valid !== 1'b1 && lat < 2000) begin
                    @(negedge sys_clk);
                    lat++;
                end
            end
        join
        repeat (4) @(negedge sys_clk);
        checks++;
        if (lat !== LAT_EXP) begin
            errors++;
            $display("[TB] FAIL 8n1_latency: got %0d expected %0d", lat, LAT_EXP);
        end
        checks++;
        if (valid_cnt - v0 !== 1) begin
            errors++;
            $display("[TB] FAIL 8n1_valid_cycles: got %0d expected 1", valid_cnt - v0);
        end
        checks++;
        if (last_data !== 8'hA5) begin
            errors++;
            $display("[TB] FAIL 8n1_data: got %h expected a5", last_data);
        end
        checks++;
        if ({last_pe, last_fe} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL 8n1_err_flags: got %b expected 00", {last_pe, last_fe});
        end
        checks++;
        if (ovr_cnt - o0 !== 0) begin
            errors++;
            $display("[TB] FAIL 8n1_overrun: got %0d expected 0", ovr_cnt - o0);
        end
        checks++;
        if ({busy, rx_valid} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL 8n1_idle_after: got %b expected 00", {busy, rx_valid});
        end
    endtask

    task automatic test_parity;
        int v0;
        v0 = p_valid_cnt;
        @(negedge sys_clk);
        send_bits_p({6'b0, 1'b1, 1'b0, 7'h31, 1'b0}, 10);
        repeat (4) @(negedge sys_clk);
        checks++;
        if (p_valid_cnt - v0 !== 1 || p_last_data !== 7'h31) begin
            errors++;
            $display("[TB] FAIL parity_bad_data: got cnt %0d data %h expected cnt 1 data 31", p_valid_cnt - v0, p_last_data);
        end
        checks++;
        if ({p_last_pe, p_last_fe} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL parity_bad_flags: got %b expected 10", {p_last_pe, p_last_fe});
        end
        v0 = p_valid_cnt;
        send_bits_p({6'b0, 1'b1, 1'b1, 7'h31, 1'b0}, 10);
        repeat (4) @(negedge sys_clk);
        checks++;
        if (p_valid_cnt - v0 !== 1 || p_last_data !== 7'h31) begin
            errors++;
            $display("[TB] FAIL parity_good_data: got cnt %0d data %h expected cnt 1 data 31", p_valid_cnt - v0, p_last_data);
        end
        checks++;
        if ({p_last_pe, p_last_fe} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL parity_good_flags: got %b expected 00", {p_last_pe, p_last_fe});
        end
    endtask

    task automatic test_frame_err;
        int v0;
        v0 = valid_cnt;
        @(negedge sys_clk);
        send_bits({7'b0, 8'h3C, 1'b0}, 9);
        rxd = 1'b0;
        repeat (3 * BPS) @(negedge sys_clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL break_busy: got %b expected 1", busy);
        end
        checks++;
        if (valid_cnt - v0 !== 1 || last_data !== 8'h3C) begin
            errors++;
            $display("[TB] FAIL break_data: got cnt %0d data %h expected cnt 1 data 3c", valid_cnt - v0, last_data);
        end
        checks++;
        if ({last_pe, last_fe} !== 2'b01) begin
            errors++;
            $display("[TB] FAIL break_flags: got %b expected 01", {last_pe, last_fe});
        end
        rxd = 1'b1;
        repeat (6) @(negedge sys_clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL break_release: got %b expected 0", busy);
        end
        repeat (BPS) @(negedge sys_clk);
    endtask

    task automatic test_back_to_back;
        int o0;
        o0       = ovr_cnt;
        rx_ready = 1'b0;
        @(negedge sys_clk);
        send_bits(frame8(8'h11), 10);
        send_bits(frame8(8'h22), 10);
        repeat (4) @(negedge sys_clk);
        checks++;
        if (rx_valid !== 1'b1 || rx_data !== 8'h11) begin
            errors++;
            $display("[TB] FAIL b2b_hold: got valid %b data %h expected valid 1 data 11", rx_valid, rx_data);
        end
        checks++;
        if (ovr_cnt - o0 !== 1) begin
            errors++;
            $display("[TB] FAIL b2b_overrun: got %0d expected 1", ovr_cnt - o0);
        end
        rx_ready = 1'b1;
        @(negedge sys_clk);
        checks++;
        if (rx_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_accept: got %b expected 0", rx_valid);
        end
        checks++;
        if (rx_data !== 8'h11) begin
            errors++;
            $display("[TB] FAIL b2b_data_hold: got %h expected 11", rx_data);
        end
        repeat (4) @(negedge sys_clk);
    endtask

    task automatic test_false_start;
        int v0;
        v0 = valid_cnt;
        @(negedge sys_clk);
        rxd = 1'b0;
        repeat (10) @(negedge sys_clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL glitch_busy: got %b expected 1", busy);
        end
        repeat (10) @(negedge sys_clk);
        rxd = 1'b1;
        repeat (20) @(negedge sys_clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL glitch_idle: got %b expected 0", busy);
        end
        repeat (BPS) @(negedge sys_clk);
        checks++;
        if (valid_cnt - v0 !== 0) begin
            errors++;
            $display("[TB] FAIL glitch_no_word: got %0d expected 0", valid_cnt - v0);
        end
    endtask

    task automatic test_reset_midframe;
        int v0;
        @(negedge sys_clk);
        send_bits(frame8(8'h5A), 4);
        rxd = 1'b1;
        repeat (BPS / 2) @(negedge sys_clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midframe_busy: got %b expected 1", busy);
        end
        sys_rst_n = 1'b0;
        repeat (2) @(negedge sys_clk);
        checks++;
        if ({rx_valid, parity_err, frame_err, overrun, busy} !== 5'b0 || rx_data !== 8'h00) begin
            errors++;
            $display("[TB] FAIL midframe_reset: got flags %b data %h expected 00000 00", {rx_valid, parity_err, frame_err, overrun, busy}, rx_data);
        end
        sys_rst_n = 1'b1;
        repeat (5) @(negedge sys_clk);
        v0 = valid_cnt;
        send_bits(frame8(8'h5A), 10);
        repeat (4) @(negedge sys_clk);
        checks++;
        if (valid_cnt - v0 !== 1 || last_data !== 8'h5A) begin
            errors++;
            $display("[TB] FAIL after_reset_data: got cnt %0d data %h expected cnt 1 data 5a", valid_cnt - v0, last_data);
        end
        checks++;
        if ({last_pe, last_fe} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL after_reset_flags: got %b expected 00", {last_pe, last_fe});
        end
    endtask

`ifdef UART_RX_MAJORITY_EN
    task automatic send_glitched(input logic [7:0] d, input int gbit, input int goff);
        logic [15:0] bits;
        bits = frame8(d);
        for (int i = 0; i < 10; i++) begin
            for (int c = 0; c < BPS; c++) begin
                rxd = (i == gbit + 1 && c == goff) ? ~bits[i] : bits[i];
                @(negedge sys_clk);
            end
        end
    endtask

    task automatic test_majority;
        int v0;
        v0 = valid_cnt;
        @(negedge sys_clk);
        send_glitched(8'h5A, 0, BPS / 2 + 1);
        repeat (4) @(negedge sys_clk);
        checks++;
        if (valid_cnt - v0 !== 1 || last_data !== 8'h5A) begin
            errors++;
            $display("[TB] FAIL majority_glitch: got cnt %0d data %h expected cnt 1 data 5a", valid_cnt - v0, last_data);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_8n1();
        test_parity();
        test_frame_err();
        test_back_to_back();
        test_false_start();
        test_reset_midframe();
`ifdef UART_RX_MAJORITY_EN
        test_majority();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
